// File: rtl/softmax_sum_normalizer_pkg.sv
// ============================================================================
//  Module      : softmax_sum_normalizer_pkg
//  Description : Shared defaults, FSM state encoding and a width helper for
//                the softmax sum normalizer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package softmax_sum_normalizer_pkg;

  // Default datapath geometry: Q4.4 input terms, up to 16 terms per vector
  localparam int c_IN_W_DEF    = 8;
  localparam int c_IN_FRAC_DEF = 4;
  localparam int c_MAX_N_DEF   = 16;
  localparam int c_EXP_W_DEF   = 5;

  // Fraction width handed to the reciprocal stage
  localparam int c_MANT_W      = 8;

  // Normalizer FSM states
  typedef enum logic [1:0] {
    ACC  = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Accumulator width needed to hold max_n terms of in_w bits
  function automatic int acc_width(input int in_w, input int max_n);
    return in_w + $clog2(max_n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/softmax_sum_normalizer_sat_adder.sv
// ============================================================================
//  Module      : sat_adder
//  Description : Unsigned saturating adder. Clamps to all-ones and flags the
//                carry-out so the caller can keep a sticky overflow bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_adder #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH:0] w_full;

  // Full-width sum; the extra bit is the carry that triggers saturation
  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[WIDTH];
  assign o_sum  = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/softmax_sum_normalizer.sv
// ============================================================================
//  Module      : softmax_sum_normalizer
//  Description : Accumulates a vector of unsigned exponential terms (delimited
//                by in_last), normalizes the sum to (1+f)*2^e and presents the
//                8-bit fraction f and signed exponent e downstream.
//                Optional macro SOFTMAX_NORM_ROUND_EN: round the fraction to
//                nearest (ties up) at the cost of one extra NORM-exit cycle;
//                otherwise the fraction is truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_sum_normalizer
  import softmax_sum_normalizer_pkg::*;
#(
  parameter int IN_W    = c_IN_W_DEF,
  parameter int IN_FRAC = c_IN_FRAC_DEF,
  parameter int MAX_N   = c_MAX_N_DEF,
  parameter int EXP_W   = c_EXP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [c_MANT_W-1:0]     out_mant,
  output logic signed [EXP_W-1:0] out_exp,
  output logic                    out_zero,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int c_ACC_W   = acc_width(IN_W, MAX_N);
  localparam int c_SH_W    = $clog2(c_ACC_W);
  // Exponent when the leading one already sits in the accumulator MSB
  localparam int c_EXP_TOP = c_ACC_W - 1 - IN_FRAC;

  state_t               r_state;
  logic [c_ACC_W-1:0]   r_acc;
  logic [c_SH_W-1:0]    r_sh;
  logic                 r_ovf;
  logic [c_MANT_W-1:0]  r_out_mant;
  logic [EXP_W-1:0]     r_out_exp;
  logic                 r_out_zero;
  logic                 r_out_ovf;
  logic                 r_out_valid;

  logic [c_ACC_W-1:0]   w_add_in;
  logic [c_ACC_W-1:0]   w_add_sum;
  logic                 w_add_ovf;
  logic                 w_accept;
  logic [EXP_W-1:0]     w_exp;
  logic [c_MANT_W-1:0]  w_mant_trunc;

  // Zero-extend the incoming term to accumulator width
  assign w_add_in = {{(c_ACC_W-IN_W){1'b0}}, in_data};

  sat_adder #(
    .WIDTH (c_ACC_W)
  ) u_sat_adder (
    .i_a   (r_acc),
    .i_b   (w_add_in),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  // Ready only while accumulating and never while reset is held
  assign in_ready = (r_state == ACC) && !rst;
  assign w_accept = in_valid && in_ready;

  // Exponent from the number of shifts needed to bring the leading one to MSB
  assign w_exp        = EXP_W'(c_EXP_TOP) - EXP_W'(r_sh);
  assign w_mant_trunc = r_acc[c_ACC_W-2 -: c_MANT_W];

`ifdef SOFTMAX_NORM_ROUND_EN
  localparam int c_GUARD = c_ACC_W - 2 - c_MANT_W;

  logic                r_rnd_phase;
  logic                r_rnd_up;
  logic [c_MANT_W:0]   w_mant_inc;

  // Incremented fraction; the top bit is the carry out of 0xFF
  assign w_mant_inc = {1'b0, r_out_mant} + {{c_MANT_W{1'b0}}, 1'b1};
`endif

  // Accumulate / normalize / hold controller with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_sh        <= '0;
      r_ovf       <= 1'b0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef SOFTMAX_NORM_ROUND_EN
      r_rnd_phase <= 1'b0;
      r_rnd_up    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept) begin
            r_acc <= w_add_sum;
            r_ovf <= r_ovf | w_add_ovf;
            if (in_last) begin
              r_state <= NORM;
            end
          end
        end

        NORM: begin
          if (r_acc == '0) begin
            r_out_zero <= 1'b1;
            r_out_mant <= '0;
            r_out_exp  <= '0;
            r_out_ovf  <= 1'b0;
            r_state    <= HOLD;
          end else if (!r_acc[c_ACC_W-1]) begin
            r_acc <= r_acc << 1;
            r_sh  <= r_sh + 1'b1;
          end else begin
`ifdef SOFTMAX_NORM_ROUND_EN
            if (!r_rnd_phase) begin
              // First exit cycle: capture truncated result and the guard bit
              r_out_zero  <= 1'b0;
              r_out_mant  <= w_mant_trunc;
              r_out_exp   <= w_exp;
              r_out_ovf   <= r_ovf;
              r_rnd_up    <= r_acc[c_GUARD];
              r_rnd_phase <= 1'b1;
            end else begin
              // Second exit cycle: apply the round-up, bumping e on carry
              if (r_rnd_up) begin
                r_out_mant <= w_mant_inc[c_MANT_W-1:0];
                if (w_mant_inc[c_MANT_W]) begin
                  r_out_exp <= r_out_exp + EXP_W'(1);
                end
              end
              r_rnd_phase <= 1'b0;
              r_state     <= HOLD;
            end
`else
            r_out_zero <= 1'b0;
            r_out_mant <= w_mant_trunc;
            r_out_exp  <= w_exp;
            r_out_ovf  <= r_ovf;
            r_state    <= HOLD;
`endif
          end
        end

        HOLD: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_sh        <= '0;
            r_ovf       <= 1'b0;
            r_state     <= ACC;
          end
        end

        default: begin
          r_state <= ACC;
        end
      endcase
    end
  end

  assign out_mant  = r_out_mant;
  assign out_exp   = $signed(r_out_exp);
  assign out_zero  = r_out_zero;
  assign out_ovf   = r_out_ovf;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_softmax_sum_normalizer.sv
// ============================================================================
//  Module      : tb_softmax_sum_normalizer
//  Description : Directed self-checking bench for softmax_sum_normalizer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_softmax_sum_normalizer;

  logic              clk;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [7:0]        out_mant;
  logic signed [4:0] out_exp;
  logic              out_zero;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;

  int n_checks;
  int n_fails;

`ifdef SOFTMAX_NORM_ROUND_EN
  localparam int c_RND_LAT = 1;
`else
  localparam int c_RND_LAT = 0;
`endif

  softmax_sum_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until the edge that accepts it
  task automatic send(input logic [7:0] d, input logic last);
    int guard;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_eq("send_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // Count edges after the accepting edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!out_valid) check_eq("valid_timeout", 0, 1);
  endtask

  // Complete the output handshake and confirm return to accumulation
  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, int'(out_valid), 0);
    check_eq({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check_eq("rst_in_ready",  int'(in_ready),  0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_mant",  int'(out_mant),  0);
    check_eq("rst_out_exp",   int'(out_exp),   0);
    check_eq("rst_out_zero",  int'(out_zero),  0);
    check_eq("rst_out_ovf",   int'(out_ovf),   0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", int'(in_ready), 1);

    // 3 x 1.0 -> sum 3.0 = 1.5 * 2^1, six shifts
    send(8'h10, 1'b0);
    send(8'h10, 1'b0);
    send(8'h10, 1'b1);
    check_eq("v3_ready_low", int'(in_ready), 0);
    wait_valid(lat);
    check_eq("v3_latency", lat, 8 + c_RND_LAT);
    check_eq("v3_mant", int'(out_mant), 'h80);
    check_eq("v3_exp",  int'(out_exp),  1);
    check_eq("v3_zero", int'(out_zero), 0);
    check_eq("v3_ovf",  int'(out_ovf),  0);
    consume("v3");

    // Zero sum
    send(8'h00, 1'b1);
    wait_valid(lat);
    check_eq("z_latency", lat, 2);
    check_eq("z_zero", int'(out_zero), 1);
    check_eq("z_mant", int'(out_mant), 0);
    check_eq("z_exp",  int'(out_exp),  0);
    consume("z");

    // 17 x 0xFF saturates; then hold out_ready low for 5 cycles
    for (int i = 0; i < 17; i++) send(8'hFF, (i == 16));
    wait_valid(lat);
    check_eq("sat_latency", lat, 2 + c_RND_LAT);
    check_eq("sat_ovf", int'(out_ovf), 1);
`ifdef SOFTMAX_NORM_ROUND_EN
    check_eq("sat_mant", int'(out_mant), 'h00);
    check_eq("sat_exp",  int'(out_exp),  8);
`else
    check_eq("sat_mant", int'(out_mant), 'hFF);
    check_eq("sat_exp",  int'(out_exp),  7);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_valid", int'(out_valid), 1);
      check_eq("hold_ready", int'(in_ready),  0);
      check_eq("hold_ovf",   int'(out_ovf),   1);
    end
    consume("sat");

    // Single 1/16 term: fresh accumulator, 11 shifts
    send(8'h01, 1'b1);
    wait_valid(lat);
    check_eq("lsb_latency", lat, 13 + c_RND_LAT);
    check_eq("lsb_mant", int'(out_mant), 0);
    check_eq("lsb_exp",  int'(out_exp),  -4);
    check_eq("lsb_ovf",  int'(out_ovf),  0);
    consume("lsb");

    // Reset during normalization aborts the vector
    send(8'h10, 1'b0);
    send(8'h10, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check_eq("abort_rst_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("abort_ready_back", int'(in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("abort_no_valid", int'(out_valid), 0);
    end
    send(8'h20, 1'b1);
    wait_valid(lat);
    check_eq("after_latency", lat, 8 + c_RND_LAT);
    check_eq("after_mant", int'(out_mant), 0);
    check_eq("after_exp",  int'(out_exp),  1);
    consume("after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
